// File: rtl/tb_clk_div_pkg.sv
// Shared types for the multi-channel clock divider: per-channel config record,
// handshake FSM states and the "channel is running" predicate.
package tb_clk_div_pkg;

  localparam int DIV_W_MAX = 16;

  typedef struct packed {
    logic                 en;
    logic [DIV_W_MAX-1:0] div;
  } ch_cfg_t;

  typedef enum logic [0:0] {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_e;

  // A channel only toggles when enabled with a non-zero half-period.
  function automatic logic cfg_active(input logic en, input logic [DIV_W_MAX-1:0] div);
    return en && (div != {DIV_W_MAX{1'b0}});
  endfunction

endpackage

// File: rtl/tb_clk_div_gen_if.sv
// Configuration request channel (valid/ready) of the clock divider.
interface tb_clk_div_gen_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            cfg_valid;
  logic            cfg_ready;
  logic [CH_W-1:0] cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic            cfg_en;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_en, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_en, output cfg_ready);

endinterface

// File: rtl/tb_clk_div_ch.sv
// One divided clock: half-period counter, toggle flop, active config and lock flag.
// Updates are applied only where clk_o falls (or at once when the channel is parked).
module tb_clk_div_ch
  import tb_clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    run_i,
  input  logic    upd_valid_i,
  input  ch_cfg_t upd_cfg_i,
  output logic    upd_done_o,
  output logic    clk_o,
  output logic    locked_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             en_q, en_d;
  logic             clk_q, clk_d;
  logic             locked_q, locked_d;
  logic             active_s, wrap_s;
  logic             unused_div_s;

  assign active_s     = cfg_active(en_q, DIV_W_MAX'(div_q));
  assign wrap_s       = active_s && run_i && (cnt_q == (div_q - DIV_W'(1)));
  assign upd_done_o   = upd_valid_i && (!active_s || (wrap_s && clk_q));
  assign clk_o        = clk_q;
  assign locked_o     = locked_q && !upd_valid_i;
  assign unused_div_s = |(upd_cfg_i.div >> DIV_W);

  always_comb begin
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    div_d    = div_q;
    en_d     = en_q;
    locked_d = locked_q;
    if (upd_done_o) begin
      div_d    = upd_cfg_i.div[DIV_W-1:0];
      en_d     = upd_cfg_i.en;
      cnt_d    = '0;
      clk_d    = 1'b0;
      locked_d = 1'b0;
    end else if (!active_s) begin
      cnt_d    = '0;
      clk_d    = 1'b0;
      locked_d = 1'b0;
    end else if (wrap_s) begin
      cnt_d    = '0;
      clk_d    = !clk_q;
      // Lock is gained on a rising edge that is not followed by a pending change.
      locked_d = upd_valid_i ? 1'b0 : (locked_q || !clk_q);
    end else if (run_i) begin
      cnt_d    = cnt_q + DIV_W'(1);
      locked_d = locked_q && !upd_valid_i;
    end else begin
      cnt_d    = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      div_q    <= DIV_W'(DEFAULT_DIV);
      en_q     <= 1'b1;
      clk_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      en_q     <= en_d;
      clk_q    <= clk_d;
      locked_q <= locked_d;
    end
  end

endmodule

// File: rtl/tb_clk_div_gen.sv
// Multi-channel reconfigurable clock generator: start-up delay, config handshake
// with a single pending request, and NUM_CH divider channels.
module tb_clk_div_gen
  import tb_clk_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int INIT_DLY    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  tb_clk_div_gen_if.slave   cfg_if,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] locked_o
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DLY_W = (INIT_DLY > 0) ? $clog2(INIT_DLY + 1) : 1;

  cfg_state_e        state_q, state_d;
  logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
  ch_cfg_t           pend_cfg_q, pend_cfg_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              run_s, pend_bad_s;
  logic [NUM_CH-1:0] upd_valid_s, upd_done_s;

  assign run_s           = (dly_q == DLY_W'(INIT_DLY));
  assign pend_bad_s      = (32'(pend_ch_q) >= NUM_CH);
  assign cfg_if.cfg_ready = (state_q == CFG_IDLE);

  always_comb begin
    if (run_s) begin
      dly_d = dly_q;
    end else begin
      dly_d = dly_q + DLY_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_ch_d  = pend_ch_q;
    pend_cfg_d = pend_cfg_q;
    case (state_q)
      CFG_IDLE: begin
        if (cfg_if.cfg_valid) begin
          state_d        = CFG_PEND;
          pend_ch_d      = cfg_if.cfg_ch;
          pend_cfg_d.en  = cfg_if.cfg_en;
          pend_cfg_d.div = DIV_W_MAX'(cfg_if.cfg_div);
        end else begin
          state_d = CFG_IDLE;
        end
      end
      CFG_PEND: begin
        // Out-of-range channels are dropped one cycle after acceptance.
        if (pend_bad_s || (|upd_done_s)) begin
          state_d = CFG_IDLE;
        end else begin
          state_d = CFG_PEND;
        end
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= CFG_IDLE;
      pend_ch_q  <= '0;
      pend_cfg_q <= '0;
      dly_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_ch_q  <= pend_ch_d;
      pend_cfg_q <= pend_cfg_d;
      dly_q      <= dly_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign upd_valid_s[i] = (state_q == CFG_PEND) && (32'(pend_ch_q) == i);

    tb_clk_div_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .run_i       (run_s),
      .upd_valid_i (upd_valid_s[i]),
      .upd_cfg_i   (pend_cfg_q),
      .upd_done_o  (upd_done_s[i]),
      .clk_o       (clk_o[i]),
      .locked_o    (locked_o[i])
    );
  end

endmodule

// File: tb/tb_tb_clk_div_gen.sv
// Directed bench for tb_clk_div_gen; three channels so that channel index 3 is
// representable and out of range. Expectations are queued, then popped on observation.
module tb_tb_clk_div_gen;

  localparam int NUM_CH = 3;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NUM_CH-1:0] clk_o;
  logic [NUM_CH-1:0] locked_o;
  int                n_checks = 0;
  int                n_pass   = 0;
  string             exp_tag_q[$];
  int                exp_val_q[$];

  tb_clk_div_gen_if #(.NUM_CH(NUM_CH), .DIV_W(8)) cfg_if ();

  tb_clk_div_gen #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (8),
    .DEFAULT_DIV (2),
    .INIT_DLY    (1)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .cfg_if   (cfg_if),
    .clk_o    (clk_o),
    .locked_o (locked_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input int v);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back(v);
  endtask

  task automatic check(input int obs);
    string tag;
    int    e;
    n_checks++;
    if (exp_val_q.size() == 0) begin
      tag = "queue_underflow";
      e   = -1;
    end else begin
      tag = exp_tag_q.pop_front();
      e   = exp_val_q.pop_front();
    end
    assert (obs === e) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  // Number of cycles clk_o[ch] stays at lvl, capped at budget.
  task automatic count_while(input int ch, input logic lvl, input int budget, output int n);
    n = 0;
    while (clk_o[ch] === lvl && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (cfg_if.cfg_ready !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic count_high(input int ch, input int cycles, output int hi);
    hi = 0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (clk_o[ch] === 1'b1) hi++;
    end
  endtask

  // Returns just after the accepting edge.
  task automatic send(input int ch, input int dv, input logic en);
    int w;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_div   = 8'(dv);
    cfg_if.cfg_en    = en;
    cfg_if.cfg_valid = 1'b1;
    w = 0;
    while (cfg_if.cfg_ready !== 1'b1 && w < 1000) begin
      step();
      w++;
    end
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_i            = 1'b1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_en    = 1'b0;
    step(); step(); step();

    expect_v("rst_clk_o", 0);    check(int'(clk_o));
    expect_v("rst_locked_o", 0); check(int'(locked_o));
    expect_v("rst_ready", 1);    check(int'(cfg_if.cfg_ready));

    // Start-up: INIT_DLY frozen cycle plus DEFAULT_DIV low cycles.
    rst_i = 1'b0;
    expect_v("start_first_rise", 3); count_while(0, 1'b0, 20, n); check(n);
    expect_v("start_in_phase", 7);   check(int'(clk_o));
    expect_v("start_locked", 7);     check(int'(locked_o));
    expect_v("dflt_high", 2);        count_while(0, 1'b1, 20, n); check(n);
    expect_v("dflt_low", 2);         count_while(0, 1'b0, 20, n); check(n);

    // Ratio change on ch0 one cycle into its high phase.
    send(0, 5, 1'b1);
    expect_v("ratio_ready_low", 0);   check(int'(cfg_if.cfg_ready));
    expect_v("ratio_locked_drop", 6); check(int'(locked_o));
    expect_v("ratio_old_high", 1);    check(int'(clk_o[0]));
    expect_v("ratio_ready_wait", 1);  wait_ready(30, n); check(n);
    expect_v("ratio_fell", 0);        check(int'(clk_o[0]));
    expect_v("ratio_new_low", 5);     count_while(0, 1'b0, 30, n); check(n);
    expect_v("ratio_relock", 1);      check(int'(locked_o[0]));
    expect_v("ratio_new_high", 5);    count_while(0, 1'b1, 30, n); check(n);
    count_while(1, 1'b1, 10, n);
    count_while(1, 1'b0, 10, n);
    expect_v("ch1_unchanged_high", 2); count_while(1, 1'b1, 20, n); check(n);
    expect_v("ch1_unchanged_low", 2);  count_while(1, 1'b0, 20, n); check(n);

    // Disable ch1 one cycle after its rise; the high phase must complete.
    send(1, 2, 1'b0);
    expect_v("dis_full_high", 2);   count_while(1, 1'b1, 20, n); check(n + 1);
    expect_v("dis_ready", 1);       check(int'(cfg_if.cfg_ready));
    expect_v("dis_locked", 0);      check(int'(locked_o[1]));
    expect_v("dis_parked", 0);      count_high(1, 10, n); check(n);

    // Re-enable ch1 with D=3 from the parked state.
    send(1, 3, 1'b1);
    expect_v("en_ready_wait", 1);   wait_ready(20, n); check(n);
    expect_v("en_first_rise", 3);   count_while(1, 1'b0, 20, n); check(n);
    expect_v("en_locked", 1);       check(int'(locked_o[1]));
    expect_v("en_high", 3);         count_while(1, 1'b1, 20, n); check(n);

    // Back-to-back on ch0: D=3 then D=1 held valid while the first is pending.
    send(0, 3, 1'b1);
    cfg_if.cfg_ch    = 2'(0);
    cfg_if.cfg_div   = 8'(1);
    cfg_if.cfg_en    = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    wait_ready(40, n);
    expect_v("b2b_latency_bound", 1); check(int'(n <= 11));
    expect_v("b2b_applied_low", 0);   check(int'(clk_o[0]));
    step();
    cfg_if.cfg_valid = 1'b0;
    expect_v("b2b_second_pending", 0); check(int'(cfg_if.cfg_ready));
    expect_v("b2b_d3_low_rest", 2);   count_while(0, 1'b0, 20, n); check(n);
    expect_v("b2b_d3_high", 3);       count_while(0, 1'b1, 20, n); check(n);
    expect_v("b2b_ready_back", 1);    check(int'(cfg_if.cfg_ready));
    expect_v("b2b_d1_low", 1);        count_while(0, 1'b0, 20, n); check(n);
    expect_v("b2b_d1_high", 1);       count_while(0, 1'b1, 20, n); check(n);

    // Largest half-period on ch1.
    send(1, 255, 1'b1);
    wait_ready(20, n);
    expect_v("d255_parked_at_apply", 0); check(int'(clk_o[1]));
    expect_v("d255_low", 255);  count_while(1, 1'b0, 600, n); check(n);
    expect_v("d255_high", 255); count_while(1, 1'b1, 600, n); check(n);

    // Out-of-range channel index is accepted and dropped.
    send(3, 7, 1'b1);
    expect_v("bad_ch_ready_low", 0);  check(int'(cfg_if.cfg_ready));
    expect_v("bad_ch_ready_wait", 1); wait_ready(20, n); check(n);
    expect_v("bad_ch_locked", 7);     check(int'(locked_o));

    // D=0 with en=1 parks ch2 exactly like en=0.
    send(2, 0, 1'b1);
    wait_ready(20, n);
    expect_v("d0_parked", 0);      check(int'(clk_o[2]));
    expect_v("d0_locked", 3);      check(int'(locked_o));
    expect_v("d0_stays_low", 0);   count_high(2, 10, n); check(n);

    // Asynchronous reset while ch1 is high and a request is pending.
    if (clk_o[1] !== 1'b1) count_while(1, 1'b0, 600, n);
    send(1, 4, 1'b1);
    expect_v("mid_pending", 0);    check(int'(cfg_if.cfg_ready));
    expect_v("mid_ch1_high", 1);   check(int'(clk_o[1]));
    #2;
    rst_i = 1'b1;
    #1;
    expect_v("arst_clk_o", 0);     check(int'(clk_o));
    expect_v("arst_ready", 1);     check(int'(cfg_if.cfg_ready));
    expect_v("arst_locked", 0);    check(int'(locked_o));
    step();
    rst_i = 1'b0;
    expect_v("rerun_first_rise", 3); count_while(1, 1'b0, 20, n); check(n);
    expect_v("rerun_high", 2);       count_while(1, 1'b1, 20, n); check(n);
    expect_v("rerun_low", 2);        count_while(1, 1'b0, 20, n); check(n);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
